scroll_controller: RTL and testbench
====================================

SCROLL_CONTROLLER -- requirements
Module: scroll_controller

Interface
REQ-001 Parameter REFRESH_DIV, default 25000, clk cycles per phase-counter step (minimum 2).
REQ-002 Parameter SCROLL_FRAMES, default 64, complete 16-phase refresh frames per automatic offset advance (minimum 1).
REQ-003 Parameter MAX_OFFSET, default 12, largest active_mem_offset value, equal to message length 16 minus 4 digits.
REQ-004 clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-low reset; sampled on clk rising edge.
REQ-006 pause  input  1  level; 1 holds the current offset, while refresh continues.
REQ-007 step  input  1  single-cycle pulse from an upstream debouncer; requests one manual offset advance.
REQ-008 counter  output  4  refresh phase index: bits[3:2] select the digit, bits[1:0] select the sub-phase.
REQ-009 active_mem_offset  output  4  first message character shown on digit 0.
REQ-010 an  output  4  anode enables, active-low; an[3] is digit 0 (leftmost), an[0] is digit 3.
REQ-011 frame_start  output  1  one-cycle pulse on the clk edge where counter wraps from 15 to 0.

Function
REQ-012 The prescaler shall count 0..REFRESH_DIV-1 and wrap; counter shall increment by 1 (mod 16) on the cycle the prescaler wraps.
REQ-013 an shall drive 0 only on the bit of the selected digit, and only when counter[1:0]==2'b11; all other phases shall drive an=4'b1111 (blanking while the character bus settles).
REQ-014 The frame counter shall count frame_start pulses 0..SCROLL_FRAMES-1; its wrap generates a scroll_tick.
REQ-015 FSM states: RUN, HOLD, STEP_PEND.
REQ-016 RUN: on scroll_tick, the offset shall advance; pause=1 moves to HOLD; a step pulse moves to STEP_PEND.
REQ-017 HOLD: the offset is frozen and the frame counter is held at 0; pause=0 returns to RUN; a step pulse moves to STEP_PEND.
REQ-018 STEP_PEND: on the next frame_start the offset shall advance once and the FSM shall return to HOLD if pause=1, else to RUN with the frame counter cleared.
REQ-019 active_mem_offset shall change only on the cycle frame_start is asserted, so no 4-digit frame ever mixes two offsets.
REQ-020 Advance rule: if offset==MAX_OFFSET the next value is 0, else offset+1; the offset shall never exceed MAX_OFFSET.
REQ-021 A step pulse already in STEP_PEND shall be ignored (no queueing).
REQ-022 If scroll_tick and a step pulse coincide in RUN, the offset shall advance exactly once and the FSM shall enter STEP_PEND, so the step is consumed on the following frame.
REQ-023 Changes to pause shall not disturb the prescaler, counter or an.

Reset
REQ-024 While reset==0 at a clk edge: prescaler=0, counter=0, active_mem_offset=0, frame counter=0, FSM=RUN, an=4'b1111, frame_start=0.
REQ-025 Reset asserted mid-frame or in STEP_PEND shall discard the pending step and take effect on that same edge.
REQ-026 After reset releases, the first counter increment shall occur REFRESH_DIV cycles later.

Structure
REQ-027 The FSM state encoding, the sub-phase constant ANODE_ON_PHASE=2'b11, and the message length 16 shall live in a shared display package.
REQ-028 The prescaler plus the phase counter shall be one sub-module, refresh_timer, with outputs counter and frame_start; scroll_controller instantiates it and holds the FSM, frame counter and offset.

Verification (REFRESH_DIV=2, SCROLL_FRAMES=2, MAX_OFFSET=12)
REQ-029 Reset then free-run 64 cycles -> counter steps every 2 cycles, frame_start every 32 cycles, and an cycles 0111, 1011, 1101, 1110, each for one phase per digit.
REQ-030 Free-run 13 scroll_ticks -> offset runs 0,1,...,12 then 0, changing only on frame_start edges.
REQ-031 Set pause=1 at offset 5, hold for 10 frames -> offset stays 5 and an keeps cycling; release pause -> advance occurs 2 frames later.
REQ-032 In HOLD, pulse step twice within one frame -> offset advances by exactly 1 at the next frame_start, and the state returns to HOLD.
REQ-033 Step pulse on the same cycle as scroll_tick at offset 12 -> offset goes 0, then 1 at the next frame_start.
REQ-034 Drive reset=0 for 1 cycle mid-frame while in STEP_PEND -> all outputs return to their reset values on that edge, and no advance follows.

Source files
------------

// File: rtl/scroll_controller_pkg.sv
// Shared display definitions for the scrolling 4-digit message controller:
// FSM encoding, anode timing constant, message geometry and offset advance rule.
package scroll_controller_pkg;

   localparam int MSG_LEN    = 16;
   localparam int NUM_DIGITS = 4;

   // Anodes are only enabled in the last sub-phase so the character bus can settle first.
   localparam logic [1:0] ANODE_ON_PHASE = 2'b11;

   typedef enum logic [1:0] {
      ST_RUN       = 2'd0,
      ST_HOLD      = 2'd1,
      ST_STEP_PEND = 2'd2
   } scroll_state_e;

   function automatic logic [3:0] advance_offset(input logic [3:0] cur, input logic [3:0] max_off);
      return (cur >= max_off) ? 4'd0 : cur + 4'd1;
   endfunction

endpackage

// File: rtl/scroll_controller_if.sv
// Control and display bus of the scroll controller; the controller is the slave side.
interface scroll_controller_if;
   import scroll_controller_pkg::*;

   logic                  pause;
   logic                  step;
   logic [3:0]            counter;
   logic [3:0]            active_mem_offset;
   logic [NUM_DIGITS-1:0] an;
   logic                  frame_start;

   modport master (
      output pause, step,
      input  counter, active_mem_offset, an, frame_start
   );

   modport slave (
      input  pause, step,
      output counter, active_mem_offset, an, frame_start
   );

endinterface

// File: rtl/scroll_controller_refresh_timer.sv
// Refresh timebase: prescaler dividing clk by REFRESH_DIV and the 16-phase counter,
// with a frame_start pulse marking the cycle on which the counter wraps 15 -> 0.
module refresh_timer #(
   parameter int REFRESH_DIV = 25000
) (
   input  logic       clk,
   input  logic       reset,
   output logic [3:0] counter,
   output logic       frame_start
);

   localparam int              PW         = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [PW-1:0]   PRESC_LAST = PW'(REFRESH_DIV - 1);

   logic [PW-1:0] presc_q;
   logic          presc_wrap;

   assign presc_wrap  = (presc_q == PRESC_LAST);
   assign frame_start = presc_wrap && (counter == 4'hF);

   // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset) begin
         presc_q <= '0;
         counter <= 4'd0;
      end else begin
         presc_q <= presc_wrap ? '0 : presc_q + 1'b1;
         if (presc_wrap) begin
            counter <= counter + 4'd1;
         end
      end
   end

endmodule

// File: rtl/scroll_controller.sv
// Scrolling message controller: refresh timebase, anode drive, and the RUN/HOLD/STEP_PEND
// FSM that advances the message offset only on frame boundaries.
module scroll_controller
   import scroll_controller_pkg::*;
#(
   parameter int REFRESH_DIV   = 25000,
   parameter int SCROLL_FRAMES = 64,
   parameter int MAX_OFFSET    = 12
) (
   input  logic                clk,
   input  logic                reset,
   scroll_controller_if.slave  bus
);

   localparam int              FW         = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;
   localparam logic [FW-1:0]   FRAME_LAST = FW'(SCROLL_FRAMES - 1);
   localparam logic [3:0]      OFFSET_MAX = 4'(MAX_OFFSET);

   generate
      if (REFRESH_DIV < 2 || SCROLL_FRAMES < 1 ||
          MAX_OFFSET < 0 || MAX_OFFSET > MSG_LEN - NUM_DIGITS) begin : g_bad_params
         $error("scroll_controller: parameter out of range");
      end
   endgenerate

   logic [3:0]    counter;
   logic          frame_start;
   logic          scroll_tick;
   scroll_state_e state_q, state_d;
   logic [FW-1:0] frame_cnt_q, frame_cnt_d;
   logic [3:0]    offset_q, offset_d;
   logic [3:0]    an_w;

   refresh_timer #(
      .REFRESH_DIV (REFRESH_DIV)
   ) u_refresh_timer (
      .clk         (clk),
      .reset       (reset),
      .counter     (counter),
      .frame_start (frame_start)
   );

   assign scroll_tick = frame_start && (frame_cnt_q == FRAME_LAST);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= ST_RUN;
         frame_cnt_q <= '0;
         offset_q    <= 4'd0;
      end else begin
         state_q     <= state_d;
         frame_cnt_q <= frame_cnt_d;
         offset_q    <= offset_d;
      end
   end

   // Offset updates are confined to frame_start cycles, so a frame never mixes two offsets.
   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      state_d     = state_q;
      frame_cnt_d = '0;
      offset_d    = offset_q;
      unique case (state_q)
         ST_RUN: begin
            frame_cnt_d = frame_cnt_q;
            if (frame_start) begin
               frame_cnt_d = scroll_tick ? '0 : frame_cnt_q + 1'b1;
            end
            if (scroll_tick) begin
               offset_d = advance_offset(offset_q, OFFSET_MAX);
            end
            if (bus.step) begin
               state_d     = ST_STEP_PEND;
               frame_cnt_d = '0;
            end else if (bus.pause) begin
               state_d     = ST_HOLD;
               frame_cnt_d = '0;
            end
         end
         ST_HOLD: begin
            if (bus.step) begin
               state_d = ST_STEP_PEND;
            end else if (!bus.pause) begin
               state_d = ST_RUN;
            end
         end
         ST_STEP_PEND: begin
            if (frame_start) begin
               offset_d = advance_offset(offset_q, OFFSET_MAX);
               state_d  = bus.pause ? ST_HOLD : ST_RUN;
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   // Active-low anode for the selected digit; digit 0 sits on an[3].
   always_comb begin
      an_w = 4'hF;
      if (counter[1:0] == ANODE_ON_PHASE) begin
         an_w = ~(4'b1000 >> counter[3:2]);
      end
   end

   assign bus.counter           = counter;
   assign bus.frame_start       = frame_start;
   assign bus.active_mem_offset = offset_q;
   assign bus.an                = an_w;

endmodule

// File: tb/tb_scroll_controller.sv
// Self-checking bench for scroll_controller with a time-based reference model of the
// refresh sequence and a rule-level model of the scroll modes.
module tb_scroll_controller;

   localparam int DIV       = 2;
   localparam int SF        = 2;
   localparam int MAXO      = 12;
   localparam int FRAME_CYC = DIV * 16;
   localparam int TICK_CYC  = FRAME_CYC * SF;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   scroll_controller_if bus ();

   scroll_controller #(
      .REFRESH_DIV   (DIV),
      .SCROLL_FRAMES (SF),
      .MAX_OFFSET    (MAXO)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   typedef enum {M_RUN, M_HOLD, M_PEND} mode_e;
   mode_e m_mode = M_RUN;
   int    m_t      = 0;
   int    m_off    = 0;
   int    m_frames = 0;

   function automatic logic exp_fs();
      return ((m_t + 1) % FRAME_CYC) == 0;
   endfunction

   function automatic logic [12:0] exp_vec();
      int         c;
      logic [3:0] an;
      c  = (m_t / DIV) % 16;
      an = 4'hF;
      if (c % 4 == 3) an[3 - c / 4] = 1'b0;
      return {4'(c), 4'(m_off), an, exp_fs()};
   endfunction

   function automatic logic [12:0] obs();
      return {bus.counter, bus.active_mem_offset, bus.an, bus.frame_start};
   endfunction

   function automatic int adv(input int v);
      return (v == MAXO) ? 0 : v + 1;
   endfunction

   function automatic logic tick_next();
      return m_mode == M_RUN && exp_fs() && m_frames == SF - 1;
   endfunction

   // Drive one clock with the given inputs and advance the reference model; returns at negedge.
   task automatic cycle(input logic p, input logic s, input logic r);
      logic fs;
      logic tick;
      bus.pause = p;
      bus.step  = s;
      reset     = r;
      fs        = exp_fs();
      @(posedge clk);
      if (!r) begin
         m_t = 0; m_off = 0; m_mode = M_RUN; m_frames = 0;
      end else begin
         case (m_mode)
            M_RUN: begin
               tick = fs && (m_frames == SF - 1);
               if (fs) m_frames = tick ? 0 : m_frames + 1;
               if (tick) m_off = adv(m_off);
               if (s) begin
                  m_mode = M_PEND; m_frames = 0;
               end else if (p) begin
                  m_mode = M_HOLD; m_frames = 0;
               end
            end
            M_HOLD: begin
               if (s) m_mode = M_PEND;
               else if (!p) m_mode = M_RUN;
            end
            default: begin
               if (fs) begin
                  m_off = adv(m_off); m_mode = p ? M_HOLD : M_RUN; m_frames = 0;
               end
            end
         endcase
         m_t++;
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, 1'b0, 1'b0);
         n_vec++;
         if (obs() !== 13'b0000_0000_1111_0) begin
            n_err++; $display("FAIL reset_state got=%h exp=%h", obs(), 13'b0000_0000_1111_0);
         end
      end
      cycle(1'b0, 1'b0, 1'b1);
      n_vec++;
      if (bus.counter !== 4'd0) begin
         n_err++; $display("FAIL first_step_early counter got=%0d exp=0", bus.counter);
      end
      cycle(1'b0, 1'b0, 1'b1);
      n_vec++;
      if (bus.counter !== 4'd1) begin
         n_err++; $display("FAIL first_step_late counter got=%0d exp=1", bus.counter);
      end
   endtask

   task automatic test_refresh();
      int         nfs = 0;
      int         nan = 0;
      logic [3:0] seq[$];
      logic [3:0] exp_seq[4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
      for (int i = 0; i < 64; i++) begin
         if (bus.frame_start === 1'b1) nfs++;
         if (bus.an !== 4'hF) begin
            nan++;
            if (seq.size() == 0 || seq[seq.size() - 1] !== bus.an) seq.push_back(bus.an);
         end
         cycle(1'b0, 1'b0, 1'b1);
         n_vec++;
         if (obs() !== exp_vec()) begin
            n_err++; $display("FAIL refresh_cycle t=%0t got=%h exp=%h", $time, obs(), exp_vec());
         end
      end
      n_vec++;
      if (nfs != 2) begin n_err++; $display("FAIL refresh_frame_count got=%0d exp=2", nfs); end
      n_vec++;
      if (nan != 16) begin n_err++; $display("FAIL refresh_anode_cycles got=%0d exp=16", nan); end
      for (int k = 0; k < 4; k++) begin
         n_vec++;
         if (seq.size() <= k || seq[k] !== exp_seq[k]) begin
            n_err++;
            $display("FAIL anode_order idx=%0d got=%b exp=%b", k, (seq.size() > k) ? seq[k] : 4'hx, exp_seq[k]);
         end
      end
   endtask

   task automatic test_scroll();
      int         changes = 0;
      logic [3:0] prev;
      logic       fs_before;
      cycle(1'b0, 1'b0, 1'b0);
      prev = bus.active_mem_offset;
      for (int i = 0; i < 14 * TICK_CYC && changes < 13; i++) begin
         fs_before = bus.frame_start;
         cycle(1'b0, 1'b0, 1'b1);
         n_vec++;
         if (obs() !== exp_vec()) begin
            n_err++; $display("FAIL scroll_cycle t=%0t got=%h exp=%h", $time, obs(), exp_vec());
         end
         if (bus.active_mem_offset !== prev) begin
            n_vec++;
            if (fs_before !== 1'b1 || bus.active_mem_offset !== 4'((changes + 1) % (MAXO + 1))) begin
               n_err++;
               $display("FAIL scroll_seq idx=%0d got=%0d exp=%0d on_frame_start=%b",
                        changes, bus.active_mem_offset, (changes + 1) % (MAXO + 1), fs_before);
            end
            changes++;
            prev = bus.active_mem_offset;
         end
      end
      n_vec++;
      if (changes != 13) begin n_err++; $display("FAIL scroll_count got=%0d exp=13", changes); end
   endtask

   task automatic test_pause();
      int         nan = 0;
      int         nfs = 0;
      logic [3:0] held;
      for (int i = 0; i < 8 * TICK_CYC && m_off != 5; i++) cycle(1'b0, 1'b0, 1'b1);
      n_vec++;
      if (bus.active_mem_offset !== 4'd5) begin
         n_err++; $display("FAIL pause_setup offset got=%0d exp=5", bus.active_mem_offset);
      end
      for (int i = 0; i < 10 * FRAME_CYC; i++) begin
         cycle(1'b1, 1'b0, 1'b1);
         if (bus.an !== 4'hF) nan++;
         n_vec++;
         if (obs() !== exp_vec()) begin
            n_err++; $display("FAIL pause_cycle t=%0t got=%h exp=%h", $time, obs(), exp_vec());
         end
      end
      n_vec++;
      if (bus.active_mem_offset !== 4'd5) begin
         n_err++; $display("FAIL pause_hold offset got=%0d exp=5", bus.active_mem_offset);
      end
      n_vec++;
      if (nan != 80) begin n_err++; $display("FAIL pause_anodes got=%0d exp=80", nan); end
      held = bus.active_mem_offset;
      for (int i = 0; i < 4 * FRAME_CYC && bus.active_mem_offset === held; i++) begin
         if (bus.frame_start === 1'b1) nfs++;
         cycle(1'b0, 1'b0, 1'b1);
      end
      n_vec++;
      if (nfs != 2 || bus.active_mem_offset !== 4'd6) begin
         n_err++; $display("FAIL pause_release frames got=%0d exp=2 offset got=%0d exp=6", nfs, bus.active_mem_offset);
      end
   endtask

   task automatic test_hold_step();
      int         nfs = 0;
      logic [3:0] base;
      logic [3:0] after;
      cycle(1'b1, 1'b0, 1'b1);
      cycle(1'b1, 1'b0, 1'b1);
      base = bus.active_mem_offset;
      cycle(1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b1);
      cycle(1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 2 * FRAME_CYC && bus.active_mem_offset === base; i++) begin
         if (bus.frame_start === 1'b1) nfs++;
         cycle(1'b1, 1'b0, 1'b1);
         n_vec++;
         if (obs() !== exp_vec()) begin
            n_err++; $display("FAIL hold_step_cycle t=%0t got=%h exp=%h", $time, obs(), exp_vec());
         end
      end
      after = 4'(adv(int'(base)));
      n_vec++;
      if (nfs != 1 || bus.active_mem_offset !== after) begin
         n_err++; $display("FAIL hold_step_advance frames got=%0d exp=1 offset got=%0d exp=%0d", nfs, bus.active_mem_offset, after);
      end
      for (int i = 0; i < 3 * FRAME_CYC; i++) cycle(1'b1, 1'b0, 1'b1);
      n_vec++;
      if (bus.active_mem_offset !== after) begin
         n_err++; $display("FAIL hold_step_returns_hold offset got=%0d exp=%0d", bus.active_mem_offset, after);
      end
   endtask

   task automatic test_coincide();
      bit   found = 0;
      int   nfs   = 0;
      for (int i = 0; i < 15 * TICK_CYC && !found; i++) begin
         if (m_off == MAXO && tick_next()) found = 1;
         else cycle(1'b0, 1'b0, 1'b1);
      end
      n_vec++;
      if (!found) begin
         n_err++; $display("FAIL coincide_timeout got=none exp=tick at offset %0d", MAXO);
      end
      cycle(1'b0, 1'b1, 1'b1);
      n_vec++;
      if (bus.active_mem_offset !== 4'd0) begin
         n_err++; $display("FAIL coincide_wrap offset got=%0d exp=0", bus.active_mem_offset);
      end
      for (int i = 0; i < 3 * FRAME_CYC && bus.active_mem_offset === 4'd0; i++) begin
         if (bus.frame_start === 1'b1) nfs++;
         cycle(1'b0, 1'b0, 1'b1);
      end
      n_vec++;
      if (nfs != 1 || bus.active_mem_offset !== 4'd1) begin
         n_err++; $display("FAIL coincide_step frames got=%0d exp=1 offset got=%0d exp=1", nfs, bus.active_mem_offset);
      end
   endtask

   task automatic test_reset_pend();
      for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b1);
      cycle(1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 1'b1);
      cycle(1'b0, 1'b0, 1'b0);
      n_vec++;
      if (obs() !== 13'b0000_0000_1111_0) begin
         n_err++; $display("FAIL reset_pend_state got=%h exp=%h", obs(), 13'b0000_0000_1111_0);
      end
      for (int i = 0; i < 40; i++) begin
         cycle(1'b0, 1'b0, 1'b1);
         n_vec++;
         if (obs() !== exp_vec()) begin
            n_err++; $display("FAIL reset_pend_cycle t=%0t got=%h exp=%h", $time, obs(), exp_vec());
         end
      end
      n_vec++;
      if (bus.active_mem_offset !== 4'd0) begin
         n_err++; $display("FAIL reset_pend_no_advance offset got=%0d exp=0", bus.active_mem_offset);
      end
   endtask

   task automatic test_random();
      logic p = 1'b0;
      logic s;
      logic r;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 49) == 0) p = ~p;
         s = ($urandom_range(0, 24) == 0);
         r = ($urandom_range(0, 499) != 0);
         cycle(p, s, r);
         n_vec++;
         if (obs() !== exp_vec()) begin
            n_err++; $display("FAIL random_cycle t=%0t got=%h exp=%h", $time, obs(), exp_vec());
         end
      end
   endtask

   initial begin
      bus.pause = 1'b0;
      bus.step  = 1'b0;
      reset     = 1'b0;
      @(negedge clk);
      test_reset();
      test_refresh();
      test_scroll();
      test_pause();
      test_hold_step();
      test_coincide();
      test_reset_pend();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
